// File: rtl/peripheral_display_7seg_n_pkg.sv
// display_pkg: register map, CTRL field positions, converter states and segment glyphs
// Segment vectors are active-low, bit 0 = a ... bit 6 = g.
package display_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;
  localparam int CTRL_NUMS = 0;
  localparam int CTRL_DOTS = 8;
  localparam int CTRL_FMT = 16;
  localparam int CTRL_BLINK = 17;
  localparam int CTRL_BRIGHT = 18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/peripheral_display_7seg_n_if.sv
// peripheral_display_7seg_n_if: register bus (addr, WD, WE in; RD out of the slave)
interface peripheral_display_7seg_n_if;
  logic [1:0] addr;
  logic [31:0] WD;
  logic WE;
  logic [31:0] RD;
  modport master(output addr, WD, WE, input RD);
  modport slave(input addr, WD, WE, output RD);
endinterface

// File: rtl/peripheral_display_7seg_n_bin_to_bcd_seq.sv
// bin_to_bcd_seq: double-dabble, one input bit per cycle, 4*N_DIGITS cycles per conversion
// Ports: clk, rst; start + value load (restarts if busy); busy; done pulses on the last
// step while bcd/overflow carry the finished result for the caller to latch.
module bin_to_bcd_seq import display_pkg::*; #(
  parameter int N_DIGITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [4*N_DIGITS-1:0] value,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic [4*N_DIGITS-1:0] bcd
);
  localparam int W = 4*N_DIGITS;
  localparam int CW = $clog2(W);
  localparam logic [31:0] LIMIT = 32'(pow10(N_DIGITS));
  conv_state_t state;
  logic [W-1:0] bin, work, adj;
  logic [CW-1:0] cnt;
  logic ovf_work;
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = work[4*d +: 4] > 4'd4 ? work[4*d +: 4] + 4'd3 : work[4*d +: 4];
  end
  // Digits above N_DIGITS are dropped; overflow is decided from the input instead.
  assign bcd = {adj[W-2:0], bin[W-1]};
  assign busy = state == CONV_RUN;
  assign done = busy && cnt == CW'(W-1);
  assign overflow = ovf_work;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CONV_IDLE;
      bin <= '0;
      work <= '0;
      cnt <= '0;
      ovf_work <= 1'b0;
    end else if (start) begin
      state <= CONV_RUN;
      bin <= value;
      work <= '0;
      cnt <= '0;
      ovf_work <= 32'(value) >= LIMIT;
    end else if (busy) begin
      state <= done ? CONV_IDLE : CONV_RUN;
      bin <= bin << 1;
      work <= bcd;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/peripheral_display_7seg_n.sv
// peripheral_display_7seg_n: multiplexed N-digit 7-segment driver with raw/binary modes
// Ports: clk, rst; bus (slave: addr, WD, WE, RD); hex/hex_dot/hex_sel active-low pins.
module peripheral_display_7seg_n import display_pkg::*; #(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  peripheral_display_7seg_n_if.slave bus,
  output logic [6:0] hex,
  output logic hex_dot,
  output logic [N_DIGITS-1:0] hex_sel
);
  localparam int W = 4*N_DIGITS;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(N_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [7:0] EN_MASK = 8'((1 << N_DIGITS) - 1);
  localparam logic [20:0] CTRL_MASK = {3'b111, 2'b11, EN_MASK, EN_MASK};
  logic [W-1:0] data, new_data, conv_bcd, bcd_res, shown;
  logic [20:0] ctrl, new_ctrl;
  logic [7:0] nums_en, dots_en;
  logic [31:0] thr;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] digit;
  logic [FW-1:0] frame_cnt;
  logic [3:0] nib;
  logic phase, wr_data, wr_ctrl, start, fmt, conv_busy, conv_done, conv_ovf, ovf_res;
  logic scan_wrap, digit_wrap, frame_wrap, blank, lit, on, dot_on;
  assign wr_data = bus.WE && bus.addr == ADDR_DATA;
  assign wr_ctrl = bus.WE && bus.addr == ADDR_CTRL;
  assign new_data = wr_data ? bus.WD[W-1:0] : data;
  assign new_ctrl = wr_ctrl ? bus.WD[20:0] & CTRL_MASK : ctrl;
  // The converter loads the post-write DATA so a CTRL write converts the stored value.
  assign start = (wr_data || wr_ctrl) && new_ctrl[CTRL_FMT];
  assign fmt = ctrl[CTRL_FMT];
  assign nums_en = ctrl[CTRL_NUMS +: 8];
  assign dots_en = ctrl[CTRL_DOTS +: 8];
  assign bus.RD = rst ? '0 :
                  bus.addr == ADDR_DATA ? 32'(data) :
                  bus.addr == ADDR_CTRL ? 32'(ctrl) :
                  bus.addr == ADDR_STATUS ? {30'b0, fmt && ovf_res, conv_busy} : '0;
  bin_to_bcd_seq #(.N_DIGITS(N_DIGITS)) conv (
    .clk(clk), .rst(rst), .start(start), .value(new_data),
    .busy(conv_busy), .done(conv_done), .overflow(conv_ovf), .bcd(conv_bcd)
  );
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
  assign digit_wrap = digit == DW'(N_DIGITS - 1);
  assign frame_wrap = frame_cnt == FW'(BLINK_FRAMES - 1);
  assign shown = fmt ? bcd_res : data;
  assign nib = shown[{digit, 2'b00} +: 4];
  assign thr = 32'((32'(ctrl[CTRL_BRIGHT +: 3]) + 32'd1) * SCAN_DIV) >> 3;
  assign lit = 32'(scan_cnt) < thr;
  assign blank = ctrl[CTRL_BLINK] && phase;
  assign on = lit && nums_en[digit] && !blank;
  assign dot_on = lit && dots_en[digit] && !blank;
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      ctrl <= '0;
      bcd_res <= '0;
      ovf_res <= 1'b0;
      scan_cnt <= '0;
      digit <= '0;
      frame_cnt <= '0;
      phase <= 1'b0;
      hex <= SEG_BLANK;
      hex_dot <= 1'b1;
      hex_sel <= '1;
    end else begin
      data <= new_data;
      ctrl <= new_ctrl;
      if (conv_done) begin
        bcd_res <= conv_bcd;
        ovf_res <= conv_ovf;
      end
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) begin
        digit <= digit_wrap ? '0 : digit + 1'b1;
        if (digit_wrap) begin
          frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
          phase <= phase ^ frame_wrap;
        end
      end
      hex <= on ? (fmt && ovf_res ? SEG_DASH : glyph(nib)) : SEG_BLANK;
      hex_dot <= !dot_on;
      hex_sel <= on ? ~(N_DIGITS'(1) << digit) : '1;
    end
  end
endmodule

// File: tb/tb_peripheral_display_7seg_n.sv
// tb_peripheral_display_7seg_n: register table plus scan, convert, restart, blink and reset sequences
module tb_peripheral_display_7seg_n;
  typedef struct packed {
    logic we;
    logic [1:0] addr;
    logic [31:0] wd;
    logic [1:0] raddr;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] hex;
  logic hex_dot;
  logic [3:0] hex_sel;
  int ncmp = 0;
  int nbad = 0;
  bit watch9 = 1'b0;
  bit saw9 = 1'b0;
  peripheral_display_7seg_n_if bus();
  peripheral_display_7seg_n #(.N_DIGITS(4), .SCAN_DIV(8), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      10: return 7'h08;
      11: return 7'h03;
      12: return 7'h46;
      13: return 7'h21;
      14: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  always @(negedge clk) if (watch9 && hex_sel != 4'hF && hex == seg(9)) saw9 = 1'b1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.WD = d;
    bus.WE = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.RD;
  endtask
  task automatic busy_len(output int n);
    n = 0;
    bus.addr = 2'd2;
    #1;
    while (bus.RD[0] && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk_reset(input string nm);
    logic [31:0] v;
    chk({nm, " hex"}, 32'(hex), 32'h7F);
    chk({nm, " hex_dot"}, 32'(hex_dot), 32'h1);
    chk({nm, " hex_sel"}, 32'(hex_sel), 32'hF);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("%s rd%0d", nm, a), v, 32'h0);
    end
  endtask
  task automatic scan_frame(input string nm, input logic [27:0] gl, input logic [3:0] en,
                            input logic [3:0] dots, input int exp_lit);
    int lit, prev, d, e_seg, e_dot, e_sel, e_off, e_ord;
    logic [3:0] seen;
    lit = 0; prev = -1; seen = '0;
    e_seg = 0; e_dot = 0; e_sel = 0; e_off = 0; e_ord = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (hex_sel == 4'hF) begin
        if (hex !== 7'h7F) e_off++;
      end else begin
        lit++;
        d = -1;
        for (int i = 0; i < 4; i++) if (hex_sel == ~(4'b0001 << i)) d = i;
        if (d < 0) e_sel++;
        else begin
          seen[d] = 1'b1;
          if (hex !== gl[7*d +: 7]) e_seg++;
          if (hex_dot !== ~dots[d]) e_dot++;
          if (en == 4'hF && prev >= 0 && d != prev && d != (prev + 1) % 4) e_ord++;
          prev = d;
        end
      end
    end
    chk({nm, " lit cycles"}, lit, exp_lit);
    chk({nm, " digits seen"}, 32'(seen), 32'(en));
    chk({nm, " bad glyphs"}, e_seg, 0);
    chk({nm, " bad dots"}, e_dot, 0);
    chk({nm, " bad anodes"}, e_sel, 0);
    chk({nm, " unlit segs"}, e_off, 0);
    chk({nm, " scan order"}, e_ord, 0);
  endtask
  initial begin
    vec_t tbl [6];
    int n, e;
    logic s0;
    logic [31:0] v;
    bus.addr = 2'd0;
    bus.WD = '0;
    bus.WE = 1'b0;
    tbl[0] = '{1'b1, 2'd0, 32'hFFFF12AB, 2'd0, 32'h000012AB};
    tbl[1] = '{1'b1, 2'd1, 32'hFFFEFFFF, 2'd1, 32'h001E0F0F};
    tbl[2] = '{1'b1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h00000000};
    tbl[3] = '{1'b1, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h00000000};
    tbl[4] = '{1'b0, 2'd0, 32'h00000000, 2'd0, 32'h000012AB};
    tbl[5] = '{1'b0, 2'd0, 32'h00000000, 2'd1, 32'h001E0F0F};
    repeat (3) @(negedge clk);
    chk_reset("in reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("after reset");
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wd);
      rd(tbl[i].raddr, v);
      chk($sformatf("reg vec%0d", i), v, tbl[i].exp);
    end
    wr(2'd0, 32'h000012AB);
    wr(2'd1, 32'h0000000F);
    repeat (2) @(negedge clk);
    rd(2'd2, v);
    chk("raw status", v, 32'h0);
    scan_frame("raw", {seg(1), seg(2), seg(10), seg(11)}, 4'hF, 4'h0, 4);
    wr(2'd1, 32'h001C0A0D);
    repeat (2) @(negedge clk);
    scan_frame("dots", {seg(1), seg(2), seg(10), seg(11)}, 4'b1101, 4'b1010, 24);
    wr(2'd0, 32'd1234);
    wr(2'd1, 32'h0001000F);
    busy_len(n);
    chk("1234 busy", n, 16);
    repeat (2) @(negedge clk);
    rd(2'd2, v);
    chk("1234 status", v, 32'h0);
    scan_frame("bin1234", {seg(1), seg(2), seg(3), seg(4)}, 4'hF, 4'h0, 4);
    wr(2'd0, 32'd10000);
    busy_len(n);
    chk("10000 busy", n, 16);
    repeat (2) @(negedge clk);
    rd(2'd2, v);
    chk("10000 overflow", v, 32'h2);
    scan_frame("dashes", {4{7'h3F}}, 4'hF, 4'h0, 4);
    watch9 = 1'b1;
    wr(2'd0, 32'd9999);
    repeat (4) @(negedge clk);
    wr(2'd0, 32'd42);
    busy_len(n);
    chk("restart busy", n, 16);
    repeat (2) @(negedge clk);
    rd(2'd2, v);
    chk("42 status", v, 32'h0);
    scan_frame("bin42", {seg(0), seg(0), seg(4), seg(2)}, 4'hF, 4'h0, 4);
    watch9 = 1'b0;
    chk("9999 shown", 32'(saw9), 32'h0);
    wr(2'd1, 32'h0005000F);
    busy_len(n);
    repeat (2) @(negedge clk);
    scan_frame("bright1", {seg(0), seg(0), seg(4), seg(2)}, 4'hF, 4'h0, 8);
    wr(2'd1, 32'h001E000F);
    repeat (3) @(negedge clk);
    s0 = hex_sel != 4'hF;
    n = 0;
    while ((hex_sel != 4'hF) == s0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      s0 = hex_sel != 4'hF;
      n = 1;
      while (n < 200) begin
        @(negedge clk);
        if ((hex_sel != 4'hF) != s0) break;
        n++;
      end
      chk($sformatf("blink run%0d", k), n, 64);
    end
    wr(2'd1, 32'h001D000F);
    busy_len(n);
    wr(2'd0, 32'd1234);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid-conv reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("post-abort");
    wr(2'd1, 32'h001D000F);
    n = 0;
    e = 0;
    bus.addr = 2'd2;
    #1;
    while (bus.RD[0] && n < 40) begin
      if (hex_sel != 4'hF && hex !== seg(0)) e++;
      n++;
      @(negedge clk);
      #1;
    end
    chk("zero busy", n, 16);
    chk("stale bcd glyphs", e, 0);
    repeat (2) @(negedge clk);
    scan_frame("bin0", {4{seg(0)}}, 4'hF, 4'h0, 32);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
